// File: rtl/board_pkg.sv
// Shared definitions for the 6x6 pair-matching board.
// Contents: board geometry constants, cell index and board vector types,
// and the controller state encoding.
package board_pkg;
  localparam int CELLS = 36;
  localparam int ROWS  = 6;
  localparam int COLS  = 6;
  localparam int PAIRS = 18;

  typedef logic [5:0]       cell_idx_t;
  typedef logic [CELLS-1:0] board_vec_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ONE   = 3'd1,
    WAIT  = 3'd2,
    APPLY = 3'd3,
    WON   = 3'd4
  } ctrl_state_t;
endpackage

// File: rtl/board_controller_if.sv
// Signal bundle between the board controller and its neighbours
// (input decoder, matcher, renderer).
//   start, click, click_pos, en_input, ms, mf : into the controller
//   sel_bus, hidden_bus, score, pairs_left,
//   busy, game_won, err_timeout, state         : out of the controller
// state is a debug view of the controller FSM.
// Handshake: a click is accepted only in the cycle where click=1 and
// en_input=1; there is no back-pressure, an unaccepted click is dropped.
// ms/mf are levels from the matcher and only their rising edges matter.
// modport master = the environment side, modport slave = the controller.
interface board_controller_if #(parameter int SCORE_W = 8);
  import board_pkg::*;

  logic               start;
  logic               click;
  cell_idx_t          click_pos;
  logic               en_input;
  logic               ms;
  logic               mf;
  board_vec_t         sel_bus;
  board_vec_t         hidden_bus;
  logic [SCORE_W-1:0] score;
  logic [4:0]         pairs_left;
  logic               busy;
  logic               game_won;
  logic               err_timeout;
  ctrl_state_t        state;

  modport master (
    output start, click, click_pos, en_input, ms, mf,
    input  sel_bus, hidden_bus, score, pairs_left, busy, game_won,
           err_timeout, state
  );

  modport slave (
    input  start, click, click_pos, en_input, ms, mf,
    output sel_bus, hidden_bus, score, pairs_left, busy, game_won,
           err_timeout, state
  );
endinterface

// File: rtl/board_controller_rise_detect.sv
// Registered 1-bit rising-edge detector.
//   clk, rst (sync, active-low) : clock / reset
//   clr  : synchronous clear of the history register (new game)
//   d    : level input
//   rise : 1 when d is 1 now and was 0 in the previous cycle
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic d,
  output logic rise
);
  logic prev;

  always_ff @(posedge clk) begin
    if (!rst || clr) prev <= 1'b0;
    else             prev <= d;
  end

  assign rise = d & ~prev;
endmodule

// File: rtl/board_controller.sv
// Board controller: turns clicks into the selection/hidden vectors the
// matcher reads, reacts to matcher verdicts, tracks score and pairs left.
//   clk  : system clock
//   rst  : synchronous active-low reset
//   bus  : board_controller_if slave (see interface header for signals)
// Parameters: TIMEOUT (cycles allowed in WAIT), SCORE_W (score width).
// Optional macro BOARD_CTRL_MISS_PENALTY_EN: a matcher failure also takes
// one point off the score (saturating at 0).
module board_controller
  import board_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int SCORE_W = 8
) (
  input  logic clk,
  input  logic rst,
  board_controller_if.slave bus
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  ctrl_state_t        state_q;
  board_vec_t         sel_q;
  board_vec_t         hidden_q;
  logic [SCORE_W-1:0] score_q;
  logic [4:0]         pairs_q;
  logic [TW-1:0]      timer_q;
  logic               err_q;

  logic       ms_rise;
  logic       mf_rise;
  logic       click_ok;
  board_vec_t click_bit;
  logic [63:0] hidden_ext;

  rise_detect u_ms_rise (.clk(clk), .rst(rst), .clr(bus.start), .d(bus.ms), .rise(ms_rise));
  rise_detect u_mf_rise (.clk(clk), .rst(rst), .clr(bus.start), .d(bus.mf), .rise(mf_rise));

  // Zero-extended copy so an out-of-range click_pos never indexes past the board.
  assign hidden_ext = {{(64-CELLS){1'b0}}, hidden_q};
  assign click_bit  = board_vec_t'(1) << bus.click_pos;
  assign click_ok   = bus.click && bus.en_input &&
                      (bus.click_pos < cell_idx_t'(CELLS)) &&
                      !hidden_ext[bus.click_pos];

  always_ff @(posedge clk) begin
    if (!rst || bus.start) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      hidden_q <= '0;
      score_q  <= '0;
      pairs_q  <= 5'(PAIRS);
      timer_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (click_ok) begin
            sel_q   <= sel_q | click_bit;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (click_ok) begin
            if ((sel_q & click_bit) != '0) begin
              // Clicking the selected card again deselects it.
              sel_q   <= '0;
              state_q <= IDLE;
            end else begin
              sel_q   <= sel_q | click_bit;
              timer_q <= '0;
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          // sel_q is held so the matcher can re-sample it; success beats failure.
          if (ms_rise) begin
            state_q <= APPLY;
          end else if (mf_rise) begin
            sel_q   <= '0;
`ifdef BOARD_CTRL_MISS_PENALTY_EN
            if (score_q != '0) score_q <= score_q - 1'b1;
`endif
            state_q <= IDLE;
          end else if (timer_q == TMAX) begin
            sel_q   <= '0;
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        APPLY: begin
          hidden_q <= hidden_q | sel_q;
          sel_q    <= '0;
          if (score_q != '1) score_q <= score_q + 1'b1;
          pairs_q  <= pairs_q - 1'b1;
          state_q  <= (pairs_q == 5'd1) ? WON : IDLE;
        end
        WON: begin
          // Terminal until start or reset.
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sel_bus     = sel_q;
  assign bus.hidden_bus  = hidden_q;
  assign bus.score       = score_q;
  assign bus.pairs_left  = pairs_q;
  assign bus.busy        = (state_q == WAIT) || (state_q == APPLY);
  assign bus.game_won    = (state_q == WON);
  assign bus.err_timeout = err_q;
  assign bus.state       = state_q;
endmodule

// File: tb/tb_board_controller.sv
// Directed bench for board_controller: reset, pair match, click filtering,
// miss handling, timeout, full game and restart.
module tb_board_controller;
  import board_pkg::*;

`ifdef BOARD_CTRL_MISS_PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad   = 0;

  board_controller_if #(.SCORE_W(8)) bus ();

  board_controller #(.TIMEOUT(64), .SCORE_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Clock / reset
  always #5 clk = ~clk;

  typedef struct {
    int          pos;
    logic        en;
    logic [35:0] exp_sel;
    ctrl_state_t exp_state;
  } vec_t;

  vec_t        vecs[9];
  logic [35:0] exp_hidden;
  int          exp_score;
  int          exp_pairs;
  int          cells[$];
  int          err_seen;
  int          not_wait;

  function automatic logic [35:0] bitv(input int p);
    logic [35:0] r;
    r    = '0;
    r[p] = 1'b1;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge,
  // outputs are checked there too, well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_click(input int pos, input logic en);
    bus.click     = 1'b1;
    bus.click_pos = 6'(pos);
    bus.en_input  = en;
    tick();
    bus.click     = 1'b0;
    bus.en_input  = 1'b1;
  endtask

  task automatic check_board(input string tag, input logic [35:0] sel, input ctrl_state_t st);
    check({tag, ".sel"},    64'(bus.sel_bus),    64'(sel));
    check({tag, ".hidden"}, 64'(bus.hidden_bus), 64'(exp_hidden));
    check({tag, ".score"},  64'(bus.score),      64'(exp_score));
    check({tag, ".pairs"},  64'(bus.pairs_left), 64'(exp_pairs));
    check({tag, ".state"},  64'(bus.state),      64'(st));
  endtask

  initial begin
    bus.start = 1'b0; bus.click = 1'b0; bus.click_pos = '0;
    bus.en_input = 1'b1; bus.ms = 1'b0; bus.mf = 1'b0;
    exp_hidden = '0; exp_score = 0; exp_pairs = 18;

    // Reset for two cycles
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    check_board("reset", '0, IDLE);
    check("reset.busy", 64'(bus.busy), 64'd0);
    check("reset.won",  64'(bus.game_won), 64'd0);
    check("reset.err",  64'(bus.err_timeout), 64'd0);

    // First pair: 3 and 10, matcher success after a few cycles
    do_click(3, 1'b1);
    check_board("p1.first", bitv(3), ONE);
    do_click(10, 1'b1);
    check_board("p1.second", bitv(3) | bitv(10), WAIT);
    check("p1.busy", 64'(bus.busy), 64'd1);
    for (int i = 0; i < 5; i++) tick();
    check_board("p1.hold", bitv(3) | bitv(10), WAIT);
    bus.ms = 1'b1;  // stays high afterwards on purpose
    tick();
    check_board("p1.apply", bitv(3) | bitv(10), APPLY);
    check("p1.apply_busy", 64'(bus.busy), 64'd1);
    tick();
    exp_hidden = bitv(3) | bitv(10); exp_score = 1; exp_pairs = 17;
    check_board("p1.done", '0, IDLE);
    check("p1.busy_after", 64'(bus.busy), 64'd0);

    // Click filtering table
    vecs[0] = '{5,  1'b1, bitv(5),          ONE};
    vecs[1] = '{5,  1'b1, '0,               IDLE};
    vecs[2] = '{3,  1'b1, '0,               IDLE};
    vecs[3] = '{40, 1'b1, '0,               IDLE};
    vecs[4] = '{12, 1'b0, '0,               IDLE};
    vecs[5] = '{63, 1'b1, '0,               IDLE};
    vecs[6] = '{0,  1'b1, bitv(0),          ONE};
    vecs[7] = '{10, 1'b1, bitv(0),          ONE};
    vecs[8] = '{1,  1'b1, bitv(0) | bitv(1), WAIT};
    for (int i = 0; i < 9; i++) begin
      do_click(vecs[i].pos, vecs[i].en);
      check_board($sformatf("vec%0d", i), vecs[i].exp_sel, vecs[i].exp_state);
    end

    // Miss: mf rises while 0 and 1 are selected (ms held high is not an edge)
    bus.mf = 1'b1;
    tick();
    if (PEN) exp_score = (exp_score > 0) ? exp_score - 1 : 0;
    check_board("miss1", '0, IDLE);
    bus.mf = 1'b0;
    tick();
    do_click(0, 1'b1);
    do_click(1, 1'b1);
    bus.mf = 1'b1;
    tick();
    if (PEN) exp_score = (exp_score > 0) ? exp_score - 1 : 0;
    check_board("miss2", '0, IDLE);
    bus.mf = 1'b0;

    // Timeout with ms still held high from the first pair
    do_click(7, 1'b1);
    do_click(8, 1'b1);
    check_board("to.enter", bitv(7) | bitv(8), WAIT);
    err_seen = 0; not_wait = 0;
    for (int i = 0; i < 63; i++) begin
      tick();
      if (bus.err_timeout) err_seen++;
      if (bus.state != WAIT) not_wait++;
    end
    check("to.early_err", 64'(err_seen), 64'd0);
    check("to.left_wait", 64'(not_wait), 64'd0);
    tick();
    check("to.err_pulse", 64'(bus.err_timeout), 64'd1);
    check_board("to.done", '0, IDLE);
    tick();
    check("to.err_clear", 64'(bus.err_timeout), 64'd0);
    bus.ms = 1'b0;
    tick();

    // Remaining 17 pairs
    for (int c = 0; c < 36; c++) if (c != 3 && c != 10) cells.push_back(c);
    for (int i = 0; i < 17; i++) begin
      do_click(cells[2*i], 1'b1);
      do_click(cells[2*i+1], 1'b1);
      bus.ms = 1'b1;
      tick();
      check($sformatf("pair%0d.apply", i), 64'(bus.state), 64'(APPLY));
      bus.ms = 1'b0;
      tick();
      exp_hidden = exp_hidden | bitv(cells[2*i]) | bitv(cells[2*i+1]);
      exp_score++;
      exp_pairs--;
      check_board($sformatf("pair%0d", i), '0, (i == 16) ? WON : IDLE);
    end
    check("won.level", 64'(bus.game_won), 64'd1);
    check("won.hidden_all", 64'(bus.hidden_bus), 64'hF_FFFF_FFFF);
    check("won.busy", 64'(bus.busy), 64'd0);
    do_click(5, 1'b1);
    check_board("won.click", '0, WON);

    // New game restores the board
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    exp_hidden = '0; exp_score = 0; exp_pairs = 18;
    check_board("restart", '0, IDLE);
    check("restart.won", 64'(bus.game_won), 64'd0);

    // start mid-WAIT abandons the pair
    do_click(2, 1'b1);
    do_click(4, 1'b1);
    check_board("midwait", bitv(2) | bitv(4), WAIT);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_board("midwait.start", '0, IDLE);

    // Reset wins over start
    do_click(6, 1'b1);
    rst = 1'b0; bus.start = 1'b1;
    tick();
    rst = 1'b1; bus.start = 1'b0;
    check_board("rst_prio", '0, IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/board_controller.md
Name: board_controller

Overview:
- Sequences the 6x6 pair-matching board around the matcher.
- Owns the selection and hidden registers and turns player clicks into the sel_bus/hidden_bus the matcher reads.
- Reacts to matcher success/failure by hiding or deselecting cards, and tracks score and pairs remaining.
- Sits between the input decoder (cursor + click strobe) and the matcher/board renderer.

Parameters:
- CELLS, 36, number of board cells (6x6)
- PAIRS, 18, number of card pairs (CELLS/2)
- TIMEOUT, 64, cycles allowed in WAIT before a verdict is abandoned
- SCORE_W, 8, width of the score counter

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
- start  in  1  one-cycle pulse: begin a new game
- click  in  1  one-cycle click strobe
- click_pos  in  6  cell index of the click (row*6+col)
- en_input  in  1  from matcher; 1 = matcher idle and clicks may be accepted
- ms  in  1  matcher success level
- mf  in  1  matcher failure level
- sel_bus  out  CELLS  one-hot-per-cell selection, at most 2 bits set
- hidden_bus  out  CELLS  1 = cell removed from board
- score  out  SCORE_W  pairs matched this game
- pairs_left  out  5  remaining pairs
- busy  out  1  1 in WAIT and APPLY
- game_won  out  1  level, 1 in WON
- err_timeout  out  1  one-cycle pulse when a WAIT times out

Behaviour:
- Reset (rst=0) or start=1 produces the following on the next edge:
  - sel_bus=0, hidden_bus=0, score=0, pairs_left=PAIRS
  - busy=0, game_won=0, err_timeout=0, timer=0, state=IDLE
  - ms/mf edge registers cleared
  - rst has priority over start; start acts in any state, including mid-WAIT.
- Valid click: click=1 AND en_input=1 AND click_pos<CELLS AND hidden_bus[click_pos]=0. Any other click is ignored with no state change.
- FSM states: IDLE (0 selected), ONE (1 selected), WAIT (2 selected), APPLY, WON.
- IDLE + valid click: set sel_bus[click_pos], go to ONE. Latency 1 cycle.
- ONE + valid click:
  - On the already-selected cell: clear it, go to IDLE (toggle-off).
  - Otherwise: set the second bit, go to WAIT, timer=0.
- WAIT:
  - sel_bus is held stable (the matcher re-samples it after its 3-cycle cooldown).
  - Clicks are ignored; timer increments each cycle.
  - ms/mf are levels: act only on a rising edge (previous-cycle registered value 0, current 1).
  - ms rising: go to APPLY.
  - mf rising: clear sel_bus, go to IDLE.
  - Both rising in the same cycle: ms wins.
  - timer reaches TIMEOUT-1 with no edge: clear sel_bus, pulse err_timeout for 1 cycle, go to IDLE.
- APPLY (exactly 1 cycle):
  - hidden_bus |= sel_bus; sel_bus=0.
  - score += 1, saturating at all-ones.
  - pairs_left -= 1.
  - If the pre-decrement pairs_left is 1: go to WON, else go to IDLE.
- WON: game_won=1; clicks ignored; leave only via start or rst.
- pairs_left never underflows: the decrement is only possible from APPLY, and APPLY is only reachable with pairs_left>=1.
- A hidden cell is never selectable; sel_bus AND hidden_bus is always 0.
- busy=1 exactly in WAIT and APPLY.

Optional Feature:
- Macro: BOARD_CTRL_MISS_PENALTY_EN.
- Defined: an mf rising edge in WAIT also decrements score, saturating at 0. A timeout does not affect score.
- Undefined: score is modified only by APPLY, and the mf path leaves score untouched.

Decomposition:
- Shared package board_pkg:
  - constants CELLS=36, ROWS=6, COLS=6, PAIRS=18
  - typedef cell_idx_t (6-bit)
  - typedef board_vec_t (CELLS-bit)
  - enum ctrl_state_t {IDLE, ONE, WAIT, APPLY, WON}
- One natural sub-module: rise_detect. A registered 1-bit rising-edge detector with the same clk/rst; instantiated twice, for ms and mf.

Test Plan:
- Reset with rst=0 for 2 cycles, then release -> sel_bus=0, hidden_bus=0, pairs_left=18, score=0, busy=0, game_won=0.
- Click pos 3, then pos 10 (en_input=1); ms rises 6 cycles later -> sel_bus=bit3|bit10 until APPLY; then hidden_bus=bit3|bit10, sel_bus=0, score=1, pairs_left=17, state IDLE.
- Click pos 5 twice -> sel_bus goes bit5 then 0. Click hidden pos 3 -> ignored. Click pos 40 -> ignored. Click with en_input=0 -> ignored.
- Select 0 and 1; mf rises -> sel_bus=0, hidden unchanged. Score unchanged without the macro; with BOARD_CTRL_MISS_PENALTY_EN and score=1 -> score=0, then another miss keeps score at 0.
- Select 7 and 8 with no ms/mf for 64 cycles -> err_timeout pulses once on cycle 64, sel_bus=0. A held-high ms from earlier produces no action (no rising edge).
- Play 18 successful pairs -> after the last APPLY, pairs_left=0, game_won=1, hidden_bus all ones. Further clicks are ignored. start pulse -> full board restored, game_won=0.
